// File: rtl/ram_pkg.sv
// Shared constants and types for the asymmetric dual-port RAM and its clear sequencer.
package ram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;
endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset sweep: walks every word once, one per cycle, and presents it as a write port.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int COUNT          = 1024,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = 10
) (
    input  logic          clock,
    input  logic          reset,
    output clear_state_t  state,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW-1:0] LAST_WORD = AW'(COUNT - 1);

    clear_state_t  state_next;
    logic [AW-1:0] counter;
    logic [AW-1:0] counter_next;

    // A reset arriving mid-sweep simply restarts the walk from word 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            CLEAR: begin
                if (counter == LAST_WORD) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter + AW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    always_comb begin
        clr_we   = (state == CLEAR);
        clr_addr = counter;
    end
endmodule

// File: rtl/ram_dp_asym.sv
// Single-clock true dual-port RAM: port A sees full words, port B sees narrower lanes
// of the same storage; byte enables, read valids, selectable RDW and optional output register.
module ram_dp_asym
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int B_WIDTH            = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int RDW_MODE           = RDW_OLD,
    parameter int OUT_REG            = 0,
    parameter int CLEAR_ON_RESET     = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int RATIO = DATA_WIDTH / B_WIDTH,
    localparam int AW_A  = (RAM_REGISTER_COUNT > 1) ? $clog2(RAM_REGISTER_COUNT) : 1,
    localparam int AW_B  = (RAM_REGISTER_COUNT * RATIO > 1) ? $clog2(RAM_REGISTER_COUNT * RATIO) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    busy,
    input  logic [AW_A-1:0]         address_a,
    input  logic [DATA_WIDTH-1:0]   data_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic                    wren_a,
    input  logic                    rden_a,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic                    q_a_valid,
    input  logic [AW_B-1:0]         address_b,
    input  logic [B_WIDTH-1:0]      data_b,
    input  logic [B_WIDTH/8-1:0]    be_b,
    input  logic                    wren_b,
    input  logic                    rden_b,
    output logic [B_WIDTH-1:0]      q_b,
    output logic                    q_b_valid
);
    localparam int NBA = DATA_WIDTH / 8;
    localparam int NBB = B_WIDTH / 8;
    localparam int LW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((DATA_WIDTH % B_WIDTH) != 0 || (DATA_WIDTH % 8) != 0 || (B_WIDTH % 8) != 0) begin : g_bad_width
        $error("ram_dp_asym: DATA_WIDTH must be a multiple of B_WIDTH and both a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_REGISTER_COUNT];

    clear_state_t    clr_state;
    logic            clr_we;
    logic [AW_A-1:0] clr_addr;
    logic            accept;

    ram_clear_seq #(
        .COUNT          (RAM_REGISTER_COUNT),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .AW             (AW_A)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .state    (clr_state),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy   = (clr_state == CLEAR);
    assign accept = !busy && !reset;

    function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] base,
                                                         input logic [DATA_WIDTH-1:0] wdata,
                                                         input logic [NBA-1:0]        mask);
        logic [DATA_WIDTH-1:0] merged;
        merged = base;
        for (int i = 0; i < NBA; i++) begin
            if (mask[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return merged;
    endfunction

    logic                  a_in_range;
    logic                  b_in_range;
    logic [AW_A-1:0]       word_b;
    logic [LW-1:0]         lane_b;
    logic [NBA-1:0]        wmask_a;
    logic [NBA-1:0]        wmask_b;
    logic [DATA_WIDTH-1:0] wdata_b;

    // Port B lanes are expanded to a word-wide byte mask so both ports share one merge path.
    always_comb begin
        a_in_range = 32'(address_a) < 32'(RAM_REGISTER_COUNT);
        b_in_range = 32'(address_b) < 32'(RAM_REGISTER_COUNT * RATIO);
        word_b     = AW_A'(32'(address_b) / 32'(RATIO));
        lane_b     = LW'(32'(address_b) % 32'(RATIO));
        wdata_b    = {RATIO{data_b}};
        wmask_a    = (accept && wren_a && a_in_range) ? be_a : '0;
        wmask_b    = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (accept && wren_b && b_in_range && lane_b == LW'(l)) wmask_b[l*NBB +: NBB] = be_b;
        end
    end

    logic [DATA_WIDTH-1:0] word_a_old;
    logic [DATA_WIDTH-1:0] word_b_old;
    logic [DATA_WIDTH-1:0] wr_word_a;
    logic [DATA_WIDTH-1:0] wr_word_b;

    // When both ports hit the same word, A merges on top of B's result so A owns shared bytes.
    always_comb begin
        word_a_old = a_in_range ? mem[address_a] : '0;
        word_b_old = b_in_range ? mem[word_b] : '0;
        wr_word_b  = byte_merge(word_b_old, wdata_b, wmask_b);
        wr_word_a  = byte_merge(((word_b == address_a) && (|wmask_b)) ? wr_word_b : word_a_old,
                                data_a, wmask_a);
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else begin
            if (|wmask_b) mem[word_b] <= wr_word_b;
            if (|wmask_a) mem[address_a] <= wr_word_a;
        end
    end

    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b_word;
    logic [B_WIDTH-1:0]    rd_b;

    // Same-port RDW only folds in the port's own write; the other port always sees old data.
    always_comb begin
        rd_a      = (RDW_MODE == RDW_NEW) ? byte_merge(word_a_old, data_a, wmask_a) : word_a_old;
        rd_b_word = (RDW_MODE == RDW_NEW) ? byte_merge(word_b_old, wdata_b, wmask_b) : word_b_old;
        rd_b      = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (lane_b == LW'(l)) rd_b = rd_b_word[l*B_WIDTH +: B_WIDTH];
        end
    end

    // q_x_valid is a one-cycle pulse per accepted rden_x, delayed exactly like the data;
    // there is no ready: the consumer must take q_x on the cycle valid is high.
    logic                  s1_v_a;
    logic                  s1_v_b;
    logic [DATA_WIDTH-1:0] s1_q_a;
    logic [B_WIDTH-1:0]    s1_q_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_a <= 1'b0;
            s1_v_b <= 1'b0;
            s1_q_a <= '0;
            s1_q_b <= '0;
        end else begin
            s1_v_a <= accept && rden_a;
            s1_v_b <= accept && rden_b;
            if (accept && rden_a) s1_q_a <= rd_a;
            if (accept && rden_b) s1_q_b <= rd_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_v_a;
        logic                  s2_v_b;
        logic [DATA_WIDTH-1:0] s2_q_a;
        logic [B_WIDTH-1:0]    s2_q_b;

        always_ff @(posedge clock) begin
            if (reset) begin
                s2_v_a <= 1'b0;
                s2_v_b <= 1'b0;
                s2_q_a <= '0;
                s2_q_b <= '0;
            end else begin
                s2_v_a <= s1_v_a;
                s2_v_b <= s1_v_b;
                if (s1_v_a) s2_q_a <= s1_q_a;
                if (s1_v_b) s2_q_b <= s1_q_b;
            end
        end

        assign q_a       = s2_q_a;
        assign q_a_valid = s2_v_a;
        assign q_b       = s2_q_b;
        assign q_b_valid = s2_v_b;
    end else begin : g_no_out_reg
        assign q_a       = s1_q_a;
        assign q_a_valid = s1_v_a;
        assign q_b       = s1_q_b;
        assign q_b_valid = s1_v_b;
    end
endmodule

// File: tb/tb_ram_dp_asym.sv
// Bench for ram_dp_asym: two instances (defaults, and COUNT=1000/RDW new/OUT_REG) share one
// stimulus bus and are checked against a byte-level memory model every cycle.
module tb_ram_dp_asym;
    localparam int NI = 2;

    typedef struct packed {
        logic        va;
        logic [31:0] qa;
        logic        vb;
        logic [15:0] qb;
    } rd_rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  address_a = '0;
    logic [31:0] data_a = '0;
    logic [3:0]  be_a = '0;
    logic        wren_a = 1'b0;
    logic        rden_a = 1'b0;
    logic [10:0] address_b = '0;
    logic [15:0] data_b = '0;
    logic [1:0]  be_b = '0;
    logic        wren_b = 1'b0;
    logic        rden_b = 1'b0;

    logic        busy0, busy1, qav0, qav1, qbv0, qbv1;
    logic [31:0] q_a0, q_a1;
    logic [15:0] q_b0, q_b1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_dp_asym u_dut (
        .clock(clock), .reset(reset), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .rden_a(rden_a),
        .q_a(q_a0), .q_a_valid(qav0),
        .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .rden_b(rden_b),
        .q_b(q_b0), .q_b_valid(qbv0)
    );

    ram_dp_asym #(.RAM_REGISTER_COUNT(1000), .RDW_MODE(1), .OUT_REG(1)) u_alt (
        .clock(clock), .reset(reset), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .rden_a(rden_a),
        .q_a(q_a1), .q_a_valid(qav1),
        .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .rden_b(rden_b),
        .q_b(q_b1), .q_b_valid(qbv1)
    );

    // ---------------- model: memory as a flat byte array per instance ----------------
    int          m_count [NI] = '{1024, 1000};
    int          m_rdw   [NI] = '{0, 1};
    int          m_lat   [NI] = '{1, 2};
    logic [7:0]  m_bytes [NI][4096];
    int          m_left  [NI] = '{0, 0};
    logic [31:0] exp_qa  [NI];
    logic        exp_va  [NI];
    logic [15:0] exp_qb  [NI];
    logic        exp_vb  [NI];
    rd_rec_t     exp_q0[$];
    rd_rec_t     exp_q1[$];
    logic        model_live = 1'b0;

    task automatic model_step(input int i, output rd_rec_t r, output logic was_reset);
        int         nw;
        logic [7:0] bv;
        nw = m_count[i];
        r = '0;
        was_reset = reset;
        if (reset) begin
            for (int b = 0; b < 4 * nw; b++) m_bytes[i][b] = 8'h00;
            m_left[i] = nw;
            return;
        end
        if (m_left[i] > 0) begin
            m_left[i]--;
            return;
        end
        if (rden_a) begin
            r.va = 1'b1;
            if (int'(address_a) < nw) begin
                for (int k = 0; k < 4; k++) begin
                    bv = m_bytes[i][4 * int'(address_a) + k];
                    if (m_rdw[i] == 1 && wren_a && be_a[k]) bv = data_a[8*k +: 8];
                    r.qa[8*k +: 8] = bv;
                end
            end
        end
        if (rden_b) begin
            r.vb = 1'b1;
            if (int'(address_b) < 2 * nw) begin
                for (int k = 0; k < 2; k++) begin
                    bv = m_bytes[i][2 * int'(address_b) + k];
                    if (m_rdw[i] == 1 && wren_b && be_b[k]) bv = data_b[8*k +: 8];
                    r.qb[8*k +: 8] = bv;
                end
            end
        end
        if (wren_b && int'(address_b) < 2 * nw)
            for (int k = 0; k < 2; k++)
                if (be_b[k]) m_bytes[i][2 * int'(address_b) + k] = data_b[8*k +: 8];
        if (wren_a && int'(address_a) < nw)
            for (int k = 0; k < 4; k++)
                if (be_a[k]) m_bytes[i][4 * int'(address_a) + k] = data_a[8*k +: 8];
    endtask

    always @(posedge clock) begin
        rd_rec_t r;
        logic    rst;
        for (int i = 0; i < NI; i++) begin
            model_step(i, r, rst);
            if (rst) begin
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
                for (int k = 1; k < m_lat[i]; k++) begin
                    if (i == 0) exp_q0.push_back('0); else exp_q1.push_back('0);
                end
                exp_qa[i] = '0; exp_va[i] = 1'b0; exp_qb[i] = '0; exp_vb[i] = 1'b0;
                model_live = 1'b1;
            end else begin
                if (i == 0) begin
                    exp_q0.push_back(r); r = exp_q0.pop_front();
                end else begin
                    exp_q1.push_back(r); r = exp_q1.pop_front();
                end
                exp_va[i] = r.va;
                exp_vb[i] = r.vb;
                if (r.va) exp_qa[i] = r.qa;
                if (r.vb) exp_qb[i] = r.qb;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_live) begin
            check("busy0", 32'(busy0), 32'(m_left[0] > 0));
            check("q_a_valid0", 32'(qav0), 32'(exp_va[0]));
            check("q_a0", q_a0, exp_qa[0]);
            check("q_b_valid0", 32'(qbv0), 32'(exp_vb[0]));
            check("q_b0", 32'(q_b0), 32'(exp_qb[0]));
            check("busy1", 32'(busy1), 32'(m_left[1] > 0));
            check("q_a_valid1", 32'(qav1), 32'(exp_va[1]));
            check("q_a1", q_a1, exp_qa[1]);
            check("q_b_valid1", 32'(qbv1), 32'(exp_vb[1]));
            check("q_b1", 32'(q_b1), 32'(exp_qb[1]));
        end
    end

    // ---------------- drivers ----------------
    task automatic op_a(input logic wr, input logic rd, input logic [9:0] addr,
                        input logic [31:0] d, input logic [3:0] be);
        wren_a = wr; rden_a = rd; address_a = addr; data_a = d; be_a = be;
    endtask

    task automatic op_b(input logic wr, input logic rd, input logic [10:0] addr,
                        input logic [15:0] d, input logic [1:0] be);
        wren_b = wr; rden_b = rd; address_b = addr; data_b = d; be_b = be;
    endtask

    task automatic tick();
        @(negedge clock);
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic measure_busy(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 2000 && (busy0 || busy1); n++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            @(negedge clock);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic [9:0]  aa;
        logic [10:0] ab;

        repeat (3) @(negedge clock);
        check("reset_q_a0", q_a0, 32'h0);
        check("reset_q_a_valid0", 32'(qav0), 32'h0);
        check("reset_busy0", 32'(busy0), 32'h1);
        reset = 1'b0;

        measure_busy(c0, c1);
        check("sweep_cycles0", 32'(c0), 32'd1024);
        check("sweep_cycles1", 32'(c1), 32'd1000);

        for (int a = 0; a < 1024; a++) begin
            op_a(1'b0, 1'b1, 10'(a), 32'h0, 4'h0);
            op_b(1'b0, 1'b1, 11'(2 * a + (a % 2)), 16'h0, 2'b00);
            tick();
        end
        check("cleared_last_word", q_a0, 32'h0);

        op_a(1'b1, 1'b0, 10'd5, 32'hDEADBEEF, 4'hF);
        tick();
        op_b(1'b0, 1'b1, 11'd10, 16'h0, 2'b00);
        tick();
        check("lane10", 32'(q_b0), 32'h0000BEEF);
        check("lane10_valid", 32'(qbv0), 32'h1);
        op_b(1'b0, 1'b1, 11'd11, 16'h0, 2'b00);
        tick();
        check("lane11", 32'(q_b0), 32'h0000DEAD);

        op_a(1'b1, 1'b0, 10'd5, 32'h11111111, 4'b0011);
        op_b(1'b1, 1'b0, 11'd10, 16'hAAAA, 2'b11);
        tick();
        op_a(1'b1, 1'b0, 10'd5, 32'h00000022, 4'b0001);
        op_b(1'b1, 1'b0, 11'd11, 16'h0033, 2'b01);
        tick();
        op_a(1'b0, 1'b1, 10'd5, 32'h0, 4'h0);
        tick();
        check("a_wins_and_disjoint", q_a0, 32'hDE331122);

        op_a(1'b1, 1'b1, 10'd7, 32'h12345678, 4'hF);
        tick();
        check("rdw_old_first", q_a0, 32'h0);
        op_a(1'b1, 1'b1, 10'd7, 32'hCAFEF00D, 4'hF);
        op_b(1'b0, 1'b1, 11'd14, 16'h0, 2'b00);
        tick();
        check("rdw_old_second", q_a0, 32'h12345678);
        check("cross_port_old", 32'(q_b0), 32'h00005678);
        check("rdw_new_first", q_a1, 32'h12345678);
        tick();
        check("rdw_new_second", q_a1, 32'hCAFEF00D);
        check("cross_port_old_alt", 32'(q_b1), 32'h00005678);

        op_a(1'b0, 1'b1, 10'd1000, 32'h0, 4'h0);
        tick();
        check("outreg_valid_c0", 32'(qav1), 32'h0);
        op_a(1'b0, 1'b1, 10'd5, 32'h0, 4'h0);
        tick();
        check("outreg_valid_c1", 32'(qav1), 32'h1);
        check("out_of_range_q", q_a1, 32'h0);
        tick();
        check("outreg_valid_c2", 32'(qav1), 32'h1);
        check("outreg_q_c2", q_a1, 32'hDE331122);
        tick();
        check("outreg_valid_c3", 32'(qav1), 32'h0);
        check("outreg_hold", q_a1, 32'hDE331122);

        for (int c = 0; c < 300; c++) begin
            aa = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(0, 15));
            ab = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1990, 2047)) : 11'($urandom_range(0, 31));
            op_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, $urandom(), 4'($urandom_range(0, 15)));
            op_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, 16'($urandom()), 2'($urandom_range(0, 3)));
            tick();
        end

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        check("mid_sweep_busy", 32'(busy0), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        measure_busy(c0, c1);
        check("restart_sweep_cycles0", 32'(c0), 32'd1024);
        check("restart_sweep_cycles1", 32'(c1), 32'd1000);
        op_a(1'b0, 1'b1, 10'd5, 32'h0, 4'h0);
        tick();
        check("post_sweep_word5", q_a0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
